// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the hex seven-segment display driver:
// segment width, hex-to-segment table and output polarity helper.
package sseg_pkg;

  localparam int SEG_W      = 7;
  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // High-true a..g patterns, bit0 = a
  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

  function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] seg,
                                                 input logic             active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/sseg_scan.sv
// Scan sequencer: per-digit hold divider, digit index counter and registered
// one-hot anode select for common-anode multiplexed displays.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [NUM_DIGITS-1:0] hot;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Anode follows the index one edge later, in step with the top's seg_scan register
  always_comb begin
    hot = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      hot[i] = (idx_q == IDX_W'(i));
    end
    anode_d = (ACTIVE_LOW != 0) ? ~hot : hot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
    end
  end

  assign idx   = idx_q;
  assign anode = anode_q;

endmodule

// File: rtl/sseg_display.sv
// N-digit hex display driver: capture, blanking, decode, parallel and scanned
// outputs. Optional blink support is enabled with SSEG_DISPLAY_BLINK_EN.
module sseg_display
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned SCAN_DIV   = 50000
`ifdef SSEG_DISPLAY_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV  = 12500000
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          blank_lz,
  input  logic [NUM_DIGITS-1:0]         dig_en,
`ifdef SSEG_DISPLAY_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  output logic [SEG_W*NUM_DIGITS-1:0]   segments,
  output logic [SEG_W-1:0]              seg_scan,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic                          upd
);

  localparam int VAL_W  = 4 * NUM_DIGITS;
  localparam int SEGS_W = SEG_W * NUM_DIGITS;
  localparam logic POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF = apply_pol(SEG_BLANK, POL_LOW);

  logic [VAL_W-1:0]  value_q, value_d;
  logic              ld_pend_q, ld_pend_d;
  logic              upd_q, upd_d;
  logic [SEGS_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0]  seg_scan_q, seg_scan_d;

  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        nib;
  logic              upper_zero;
  logic              blank;

  sseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .idx   (scan_idx),
    .anode (anode)
  );

`ifdef SSEG_DISPLAY_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    blink_on_d  = blink_on_q;
    if (blink_cnt_q == BLK_MAX) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  always_comb begin
    value_d   = load ? value : value_q;
    ld_pend_d = load;
    upd_d     = ld_pend_q;
  end

  // Walk from the top digit down so upper_zero covers every digit j >= i
  always_comb begin
    seg_d      = '0;
    nib        = '0;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib        = value_q[4*i +: 4];
      upper_zero = upper_zero && (nib == 4'h0);
      blank      = !dig_en[i] || (blank_lz && (i > 0) && upper_zero);
`ifdef SSEG_DISPLAY_BLINK_EN
      blank      = blank || (blink_mask[i] && !blink_on_q);
`endif
      seg_d[SEG_W*i +: SEG_W] = apply_pol(blank ? SEG_BLANK : hex_to_seg(nib), POL_LOW);
    end
  end

  // Taken from seg_d so seg_scan always matches the segments slice it shows
  always_comb begin
    seg_scan_d = SEG_OFF;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scan_idx == IDX_W'(i)) begin
        seg_scan_d = seg_d[SEG_W*i +: SEG_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q    <= '0;
      ld_pend_q  <= 1'b0;
      upd_q      <= 1'b0;
      seg_q      <= {NUM_DIGITS{SEG_OFF}};
      seg_scan_q <= SEG_OFF;
    end else begin
      value_q    <= value_d;
      ld_pend_q  <= ld_pend_d;
      upd_q      <= upd_d;
      seg_q      <= seg_d;
      seg_scan_q <= seg_scan_d;
    end
  end

  assign segments = seg_q;
  assign seg_scan = seg_scan_q;
  assign upd      = upd_q;

endmodule

// File: tb/tb_sseg_display.sv
// Directed bench for sseg_display with NUM_DIGITS=6, ACTIVE_LOW=1, SCAN_DIV=4
// (BLINK_DIV=8 and a blink scenario when SSEG_DISPLAY_BLINK_EN is defined).
module tb_sseg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] value;
  logic        blank_lz;
  logic [5:0]  dig_en;
`ifdef SSEG_DISPLAY_BLINK_EN
  logic [5:0]  blink_mask;
`endif
  logic [41:0] segments;
  logic [6:0]  seg_scan;
  logic [5:0]  anode;
  logic        upd;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [41:0] SEG_ALL_OFF = 42'h3FF_FFFF_FFFF;

  always #5 clk = ~clk;

  sseg_display #(
    .NUM_DIGITS (6),
    .ACTIVE_LOW (1),
    .SCAN_DIV   (4)
`ifdef SSEG_DISPLAY_BLINK_EN
    ,
    .BLINK_DIV  (8)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .dig_en     (dig_en),
`ifdef SSEG_DISPLAY_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .segments   (segments),
    .seg_scan   (seg_scan),
    .anode      (anode),
    .upd        (upd)
  );

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b1; dig_en = 6'h3F;
`ifdef SSEG_DISPLAY_BLINK_EN
    blink_mask = 6'h00;
`endif
    #1;
    tests_run++;
    if (segments !== SEG_ALL_OFF) begin tests_failed++; $display("FAIL reset_segments got %h exp %h", segments, SEG_ALL_OFF); end
    tests_run++;
    if (anode !== 6'h3F) begin tests_failed++; $display("FAIL reset_anode got %h exp %h", anode, 6'h3F); end
    tests_run++;
    if (seg_scan !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg_scan got %h exp %h", seg_scan, 7'h7F); end
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL reset_upd got %b exp 0", upd); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [5:0] exp_an  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [6:0] exp_dig [6] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    int idx;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      idx = (c / 4) % 6;
      tests_run++;
      if (anode !== exp_an[idx]) begin tests_failed++; $display("FAIL scan_anode cycle %0d got %h exp %h", c, anode, exp_an[idx]); end
      tests_run++;
      if (seg_scan !== exp_dig[idx]) begin tests_failed++; $display("FAIL scan_seg cycle %0d got %h exp %h", c, seg_scan, exp_dig[idx]); end
    end
  endtask

  task automatic test_load();
    logic [41:0] exp = {7'h40, 7'h40, 7'h08, 7'h40, 7'h12, 7'h0E};
    @(negedge clk); blank_lz = 1'b0; value = 24'h00A05F; load = 1'b1;
    @(negedge clk); load = 1'b0;
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL load_upd_early got %b exp 0", upd); end
    @(negedge clk);
    tests_run++;
    if (segments !== exp) begin tests_failed++; $display("FAIL load_segments got %h exp %h", segments, exp); end
    tests_run++;
    if (upd !== 1'b1) begin tests_failed++; $display("FAIL load_upd got %b exp 1", upd); end
    @(negedge clk);
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL load_upd_width got %b exp 0", upd); end
  endtask

  task automatic test_blank_lz();
    logic [41:0] exp_a = {7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h0E};
    logic [41:0] exp_z = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    @(negedge clk); blank_lz = 1'b1;
    @(negedge clk);
    tests_run++;
    if (segments !== exp_a) begin tests_failed++; $display("FAIL lz_segments got %h exp %h", segments, exp_a); end
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL lz_no_upd got %b exp 0", upd); end
    value = 24'h000000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (segments !== exp_z) begin tests_failed++; $display("FAIL lz_zero got %h exp %h", segments, exp_z); end
    tests_run++;
    if (upd !== 1'b1) begin tests_failed++; $display("FAIL lz_zero_upd got %b exp 1", upd); end
  endtask

  task automatic test_dig_en();
    logic [41:0] exp_all = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    logic [41:0] exp_d0  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F};
    @(negedge clk); value = 24'h123456; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (segments !== exp_all) begin tests_failed++; $display("FAIL en_decoded got %h exp %h", segments, exp_all); end
    dig_en = 6'b111110;
    @(negedge clk);
    tests_run++;
    if (segments !== exp_d0) begin tests_failed++; $display("FAIL en_digit0 got %h exp %h", segments, exp_d0); end
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL en_no_upd got %b exp 0", upd); end
    dig_en = 6'h3F;
  endtask

  task automatic test_back_to_back();
    logic [41:0] exp1 = {6{7'h79}};
    logic [41:0] exp2 = {6{7'h00}};
    logic [41:0] exp3 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};
    @(negedge clk); blank_lz = 1'b0; value = 24'h111111; load = 1'b1;
    @(negedge clk); value = 24'h888888;
    @(negedge clk); value = 24'hFEDCBA;
    tests_run++;
    if (segments !== exp1 || upd !== 1'b1) begin tests_failed++; $display("FAIL b2b_first got %h/%b exp %h/1", segments, upd, exp1); end
    @(negedge clk); load = 1'b0;
    tests_run++;
    if (segments !== exp2 || upd !== 1'b1) begin tests_failed++; $display("FAIL b2b_second got %h/%b exp %h/1", segments, upd, exp2); end
    @(negedge clk);
    tests_run++;
    if (segments !== exp3 || upd !== 1'b1) begin tests_failed++; $display("FAIL b2b_third got %h/%b exp %h/1", segments, upd, exp3); end
    @(negedge clk);
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL b2b_end_upd got %b exp 0", upd); end
  endtask

  task automatic test_reset_mid();
    logic [41:0] exp_zero = {6{7'h40}};
    @(negedge clk); value = 24'h777777; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    #2; rst = 1'b1; load = 1'b1; value = 24'hFFFFFF;
    #1;
    tests_run++;
    if (segments !== SEG_ALL_OFF) begin tests_failed++; $display("FAIL mid_reset_segments got %h exp %h", segments, SEG_ALL_OFF); end
    tests_run++;
    if (anode !== 6'h3F) begin tests_failed++; $display("FAIL mid_reset_anode got %h exp %h", anode, 6'h3F); end
    tests_run++;
    if (upd !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_upd got %b exp 0", upd); end
    tests_run++;
    if (seg_scan !== 7'h7F) begin tests_failed++; $display("FAIL mid_reset_seg_scan got %h exp %h", seg_scan, 7'h7F); end
    @(negedge clk); rst = 1'b0; load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (segments !== exp_zero) begin tests_failed++; $display("FAIL reset_load_ignored got %h exp %h", segments, exp_zero); end
    tests_run++;
    if (anode !== 6'h3E || upd !== 1'b0) begin tests_failed++; $display("FAIL post_reset_anode_upd got %h/%b exp 3e/0", anode, upd); end
  endtask

`ifdef SSEG_DISPLAY_BLINK_EN
  task automatic test_blink();
    logic [6:0]  d0;
    logic [41:0] exp;
    @(negedge clk); rst = 1'b1; blink_mask = 6'h01;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      d0  = (((c / 8) % 2) == 0) ? 7'h40 : 7'h7F;
      exp = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, d0};
      tests_run++;
      if (segments !== exp || upd !== 1'b0) begin tests_failed++; $display("FAIL blink cycle %0d got %h/%b exp %h/0", c, segments, upd, exp); end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank_lz();
    test_dig_en();
    test_back_to_back();
    test_reset_mid();
`ifdef SSEG_DISPLAY_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sseg_display.md
Name: sseg_display

Overview:
- Parametrised N-digit hex display driver, successor to the single-digit combinational decoder.
- Captures a packed hex value on a load strobe and drives per-digit segment buses in parallel for boards with direct-wired displays.
- Also produces a time-multiplexed output (one segment bus plus digit-select strobes) for common-anode scanned displays.
- Adds registered outputs, leading-zero blanking, per-digit enables and an update pulse.

Parameters:
- NUM_DIGITS, 6, number of hex digits (1..8).
- ACTIVE_LOW, 1, 1 = segment and anode outputs low-true, so off is all ones. 0 = high-true.
- SCAN_DIV, 50000, clock cycles each digit is held in scanned output (>=1).
- BLINK_DIV, 12500000, clock cycles per blink half-period. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  capture strobe for value
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i], digit 0 is least significant
- blank_lz  in  1  leading-zero blanking enable
- dig_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
- segments  out  7*NUM_DIGITS  parallel segment buses; digit i = segments[7i+6:7i], bit0=a .. bit6=g
- seg_scan  out  7  scanned segment bus
- anode  out  NUM_DIGITS  one-hot scanned digit select
- upd  out  1  one-cycle pulse when segments first reflect a newly loaded value

Behaviour:
- Reset (async, rst=1):
  - value_q = 0.
  - segments = all off; seg_scan = off; anode = all off.
  - upd = 0; scan index = 0; scan counter = 0; blink phase = on.
- Capture:
  - Edge k with load=1: value_q <= value.
  - Edge k+1: segments updated and upd=1 for that cycle.
  - Total latency from load to segments is 2 edges.
  - Back-to-back loads: each is captured; upd pulses every cycle.
- Decode: per digit, hex 0..F maps to standard patterns, a..g with bit0=a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
  - Outputs are inverted when ACTIVE_LOW=1.
- Blanking, evaluated on value_q and the current dig_en / blank_lz, registered with segments:
  - Digit i is blank if dig_en[i]=0.
  - Digit i is also blank if blank_lz=1, i>0, and every digit j>=i is zero.
  - Digit 0 is never blanked by leading-zero logic, so value 0 shows "0".
  - dig_en and blank_lz changes take effect after one edge, with no upd pulse.
- Scan:
  - Counter runs 0..SCAN_DIV-1. At the terminal count, the index advances i -> i+1 and wraps NUM_DIGITS-1 -> 0.
  - The first cycle after reset deasserts, anode selects index 0.
  - anode and seg_scan are registered together and never glitch between digits.
  - seg_scan = the registered segments of the current index, including blanking.
- Reset mid-operation: all outputs go off asynchronously. load is ignored while rst=1.
- Width rule: value width is exactly 4*NUM_DIGITS with no padding. The scan counter width is clog2(SCAN_DIV).

Optional Feature:
- Macro: SSEG_DISPLAY_BLINK_EN.
- With the macro defined:
  - Adds input blink_mask [NUM_DIGITS].
  - A BLINK_DIV counter toggles the blink phase at each terminal count, starting in the on phase after reset.
  - During the off phase, digits with blink_mask[i]=1 are blanked in both segments and seg_scan.
  - Blink never causes an upd pulse.
- Without the macro: no blink_mask port and no blink counter; behaviour is otherwise identical.

Decomposition:
- Package sseg_pkg:
  - SEG_W=7 and SEG_BLANK constant.
  - 16-entry hex-to-segment constant table and function hex_to_seg(nibble) returning high-true a..g.
  - Function apply_pol(seg, active_low).
- Sub-module sseg_scan:
  - Contains the scan divider, index counter and one-hot anode generation.
  - Parameterised by NUM_DIGITS, SCAN_DIV and ACTIVE_LOW.
- The top level holds capture, blanking, decode and blink.

Test Plan:
All cases use NUM_DIGITS=6, ACTIVE_LOW=1, SCAN_DIV=4.
- Reset: assert rst mid-run -> segments=42'h3FF_FFFF_FFFF, anode=6'h3F, upd=0 immediately, without waiting for a clock.
- Load with blank_lz=0: load 24'h00A05F -> 2 edges later digit0=7'h0E, digit1=7'h12, digit2=7'h40, digit3=7'h08, digit4=digit5=7'h40, and upd high for one cycle.
- Leading-zero blanking: same value with blank_lz=1 -> digit5=digit4=7'h7F, digit2=7'h40 (embedded zero kept). Then value 0 -> digits5..1=7'h7F, digit0=7'h40.
- Digit enable: dig_en=6'b111110 with value 24'h123456 -> digit0=7'h7F, others decoded, no upd on the dig_en change alone.
- Scan: after reset, anode sequence 3E,3D,3B,37,2F,1F, each held 4 cycles, wrapping to 3E at cycle 24; seg_scan equals the matching segments slice each time.
- Blink (macro on, BLINK_DIV=8): blink_mask=6'h01 -> digit0 alternates decoded/7'h7F every 8 cycles while the other digits stay steady.
